// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 op codes, FSM state encoding and operand-signedness helpers.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;
    localparam int CNT_W     = $clog2(MDU_WIDTH);

    localparam logic [2:0] MDU_MUL    = 3'b000;
    localparam logic [2:0] MDU_MULH   = 3'b001;
    localparam logic [2:0] MDU_MULHSU = 3'b010;
    localparam logic [2:0] MDU_MULHU  = 3'b011;
    localparam logic [2:0] MDU_DIV    = 3'b100;
    localparam logic [2:0] MDU_DIVU   = 3'b101;
    localparam logic [2:0] MDU_REM    = 3'b110;
    localparam logic [2:0] MDU_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mdu_state_e;

    function automatic logic op_a_signed(input logic [2:0] f);
        return !(f == MDU_MULHU || f == MDU_DIVU || f == MDU_REMU);
    endfunction

    function automatic logic op_b_signed(input logic [2:0] f);
        return op_a_signed(f) && (f != MDU_MULHSU);
    endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate: yields |x| when i_neg flags a negative
// operand, and re-applies the result sign when i_neg flags a negative result.
module mdu_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_val,
    input  logic             i_neg,
    output logic [WIDTH-1:0] o_val
);

    assign o_val = i_neg ? -i_val : i_val;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit, one bit per cycle, valid/ready on both sides.
// Magnitudes are latched at accept; FIX re-applies the sign before DONE.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);

    mdu_state_e         r_state;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_a, r_b;
    logic               r_neg_res, r_neg_rem;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_in_ready, r_out_valid;
    logic [WIDTH-1:0]   r_result;

    logic               w_a_neg, w_b_neg, w_div_zero, w_ovf;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_min, w_special;
    logic [WIDTH:0]     w_shift, w_trial;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix, w_rem_fix, w_fix_res;

    assign w_a_neg    = op_a_signed(op) & a[WIDTH-1];
    assign w_b_neg    = op_b_signed(op) & b[WIDTH-1];
    assign w_min      = {1'b1, {(WIDTH-1){1'b0}}};
    assign w_div_zero = op[2] && (b == '0);
    assign w_ovf      = (op == MDU_DIV || op == MDU_REM) && (a == w_min) && (b == {WIDTH{1'b1}});
    // Divide-by-zero and signed overflow have fixed answers and skip the iteration
    assign w_special  = w_div_zero ? (op[1] ? a : {WIDTH{1'b1}})
                                   : (op[1] ? '0 : a);

    mdu_sign_fix #(.WIDTH(WIDTH)) u_mag_a (.i_val(a), .i_neg(w_a_neg), .o_val(w_a_mag));
    mdu_sign_fix #(.WIDTH(WIDTH)) u_mag_b (.i_val(b), .i_neg(w_b_neg), .o_val(w_b_mag));

    // Restoring divide step: remainder lives in the upper half, quotient shifts into the lower
    assign w_shift = {r_acc[2*WIDTH-1:WIDTH], r_a[r_cnt]};
    assign w_trial = w_shift - {1'b0, r_b};

    mdu_sign_fix #(.WIDTH(2*WIDTH)) u_fix_p (.i_val(r_acc), .i_neg(r_neg_res), .o_val(w_prod_fix));
    mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_q (.i_val(r_acc[WIDTH-1:0]), .i_neg(r_neg_res), .o_val(w_quo_fix));
    mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_r (.i_val(r_acc[2*WIDTH-1:WIDTH]), .i_neg(r_neg_rem), .o_val(w_rem_fix));

    always_comb begin
        w_fix_res = w_quo_fix;
        case (r_op)
            MDU_MUL:                       w_fix_res = w_prod_fix[WIDTH-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: w_fix_res = w_prod_fix[2*WIDTH-1:WIDTH];
            MDU_REM, MDU_REMU:             w_fix_res = w_rem_fix;
            default:                       w_fix_res = w_quo_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_neg_res   <= 1'b0;
            r_neg_rem   <= 1'b0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
        end else begin
            case (r_state)
                IDLE: if (in_valid && !flush) begin
                    r_op       <= op;
                    r_a        <= w_a_mag;
                    r_b        <= w_b_mag;
                    r_neg_res  <= w_a_neg ^ w_b_neg;
                    r_neg_rem  <= w_a_neg;
                    r_in_ready <= 1'b0;
                    r_acc      <= '0;
                    r_cnt      <= CW'(WIDTH-1);
                    if (w_div_zero || w_ovf) begin
                        r_result    <= w_special;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_state <= CALC;
                    end
                end
                CALC: if (flush) begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b1;
                end else begin
                    if (r_op[2]) begin
                        r_acc[2*WIDTH-1:WIDTH] <= w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
                        r_acc[WIDTH-1:0]       <= {r_acc[WIDTH-2:0], ~w_trial[WIDTH]};
                    end else begin
                        r_acc <= {r_acc[2*WIDTH-2:0], 1'b0}
                               + (r_b[r_cnt] ? {{WIDTH{1'b0}}, r_a} : {(2*WIDTH){1'b0}});
                    end
                    if (r_cnt == '0) r_state <= FIX;
                    else             r_cnt   <= r_cnt - CW'(1);
                end
                FIX: if (flush) begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b1;
                end else begin
                    r_result    <= w_fix_res;
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: if (flush || out_ready) begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;

endmodule
